// File: rtl/axi_riscv_resv_pkg.sv
// Shared types and address helpers for the LR/SC reservation-table arbiter.
package axi_riscv_resv_pkg;

  typedef enum logic [1:0] {
    OP_NONE      = 2'd0,
    OP_SET       = 2'd1,
    OP_CHECK_CLR = 2'd2
  } resv_op_e;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_RD_OP,
    ST_WR_OP
  } fsm_state_e;

  function automatic logic in_range(input logic [63:0] addr, input logic [63:0] lo,
                                    input logic [63:0] hi);
    return (addr >= lo) && (addr <= hi);
  endfunction

  // Clears the byte-offset bits inside one reservation granule.
  function automatic logic [63:0] granule(input logic [63:0] addr, input int unsigned gran_bytes);
    return addr & ~(64'(gran_bytes) - 64'd1);
  endfunction

endpackage

// File: rtl/axi_riscv_resv_arbiter_if.sv
// Request, grant and reservation-table signals of the arbiter; slave = arbiter view.
interface axi_riscv_resv_arbiter_if #(
  parameter int unsigned AXI_ADDR_WIDTH = 32,
  parameter int unsigned AXI_ID_WIDTH   = 4
);
  import axi_riscv_resv_pkg::*;

  logic                      rd_req_i;
  logic [AXI_ADDR_WIDTH-1:0] rd_addr_i;
  logic [AXI_ID_WIDTH-1:0]   rd_id_i;
  logic                      rd_gnt_o;
  logic                      wr_req_i;
  logic [AXI_ADDR_WIDTH-1:0] wr_addr_i;
  logic [AXI_ID_WIDTH-1:0]   wr_id_i;
  logic                      wr_excl_i;
  logic                      wr_gnt_o;
  logic                      wr_ok_o;
  logic                      wr_done_i;
  logic                      tbl_valid_o;
  resv_op_e                  tbl_op_o;
  logic [AXI_ADDR_WIDTH-1:0] tbl_addr_o;
  logic [AXI_ID_WIDTH-1:0]   tbl_id_o;
  logic                      tbl_ready_i;
  logic                      tbl_match_i;

  modport slave (
    input  rd_req_i, rd_addr_i, rd_id_i, wr_req_i, wr_addr_i, wr_id_i, wr_excl_i, wr_done_i,
           tbl_ready_i, tbl_match_i,
    output rd_gnt_o, wr_gnt_o, wr_ok_o, tbl_valid_o, tbl_op_o, tbl_addr_o, tbl_id_o
  );

  modport master (
    output rd_req_i, rd_addr_i, rd_id_i, wr_req_i, wr_addr_i, wr_id_i, wr_excl_i, wr_done_i,
           tbl_ready_i, tbl_match_i,
    input  rd_gnt_o, wr_gnt_o, wr_ok_o, tbl_valid_o, tbl_op_o, tbl_addr_o, tbl_id_o
  );

endinterface

// File: rtl/axi_riscv_rr_arb2.sv
// Two-input round-robin picker; bit 0 = read, bit 1 = write. last_q = 1 means write served last.
module axi_riscv_rr_arb2
  import axi_riscv_resv_pkg::*;
(
  input  logic       clk_i,
  input  logic       rst_i,
  input  logic [1:0] req_i,
  input  logic       advance_i,
  output logic [1:0] gnt_o
);

  logic last_q, last_d;

  always_comb begin
    gnt_o = req_i;
    if (req_i == 2'b11) gnt_o = last_q ? 2'b01 : 2'b10;
  end

  assign last_d = (advance_i && (gnt_o != 2'b00)) ? gnt_o[1] : last_q;

  always_ff @(posedge clk_i) begin
    if (rst_i) last_q <= 1'b1;
    else       last_q <= last_d;
  end

endmodule

// File: rtl/axi_riscv_resv_arbiter.sv
// Shares the LR/SC reservation table between the LR (read) and SC/write sides, and
// locks the granule of a granted write until its B handshake so no LR re-reserves it.
module axi_riscv_resv_arbiter
  import axi_riscv_resv_pkg::*;
#(
  parameter logic [63:0] ADDR_BEGIN      = 64'h0,
  parameter logic [63:0] ADDR_END        = 64'h0,
  parameter int unsigned AXI_ADDR_WIDTH  = 32,
  parameter int unsigned AXI_ID_WIDTH    = 4,
  parameter int unsigned RESV_GRAN_BYTES = 8
) (
  input logic                     clk_i,
  input logic                     rst_i,
  axi_riscv_resv_arbiter_if.slave bus
);

  typedef logic [AXI_ADDR_WIDTH-1:0] addr_t;
  typedef logic [AXI_ID_WIDTH-1:0]   id_t;

  fsm_state_e state_q, state_d;
  addr_t      addr_q, addr_d, hold_addr_q, hold_addr_d, set_addr;
  id_t        id_q, id_d;
  logic       excl_q, excl_d, hold_q, hold_d, set_hold;
  addr_t      rd_gran, wr_gran;
  logic       rd_in, wr_in, rd_elig, wr_elig;
  logic [1:0] arb_gnt;
  logic       arb_adv;
  logic       rd_gnt, wr_gnt, wr_ok, tbl_valid;
  resv_op_e   tbl_op;

  assign rd_gran = addr_t'(granule(64'(bus.rd_addr_i), RESV_GRAN_BYTES));
  assign wr_gran = addr_t'(granule(64'(bus.wr_addr_i), RESV_GRAN_BYTES));
  assign rd_in   = in_range(64'(bus.rd_addr_i), ADDR_BEGIN, ADDR_END);
  assign wr_in   = in_range(64'(bus.wr_addr_i), ADDR_BEGIN, ADDR_END);

  // Only one write may be in flight; an LR to the locked granule waits for wr_done_i.
  assign rd_elig = bus.rd_req_i && !(hold_q && (rd_gran == hold_addr_q));
  assign wr_elig = bus.wr_req_i && !hold_q;

  axi_riscv_rr_arb2 u_arb (
    .clk_i     (clk_i),
    .rst_i     (rst_i),
    .req_i     ({wr_elig, rd_elig}),
    .advance_i (arb_adv),
    .gnt_o     (arb_gnt)
  );

  always_comb begin
    state_d   = state_q;
    addr_d    = addr_q;
    id_d      = id_q;
    excl_d    = excl_q;
    rd_gnt    = 1'b0;
    wr_gnt    = 1'b0;
    wr_ok     = 1'b0;
    tbl_valid = 1'b0;
    tbl_op    = OP_NONE;
    arb_adv   = 1'b0;
    set_hold  = 1'b0;
    set_addr  = addr_q;
    unique case (state_q)
      ST_IDLE: begin
        // Out-of-range requests are answered here without touching the table.
        if (!rst_i && arb_gnt[0]) begin
          arb_adv = 1'b1;
          if (!rd_in) rd_gnt = 1'b1;
          else begin
            state_d = ST_RD_OP;
            addr_d  = rd_gran;
            id_d    = bus.rd_id_i;
            excl_d  = 1'b0;
          end
        end else if (!rst_i && arb_gnt[1]) begin
          arb_adv = 1'b1;
          if (!wr_in) begin
            wr_gnt   = 1'b1;
            wr_ok    = !bus.wr_excl_i;
            set_hold = !bus.wr_excl_i;
            set_addr = wr_gran;
          end else begin
            state_d = ST_WR_OP;
            addr_d  = wr_gran;
            id_d    = bus.wr_id_i;
            excl_d  = bus.wr_excl_i;
          end
        end
      end
      ST_RD_OP: begin
        tbl_valid = 1'b1;
        tbl_op    = OP_SET;
        if (bus.tbl_ready_i) begin
          rd_gnt  = 1'b1;
          state_d = ST_IDLE;
        end
      end
      ST_WR_OP: begin
        tbl_valid = 1'b1;
        tbl_op    = OP_CHECK_CLR;
        if (bus.tbl_ready_i) begin
          wr_gnt   = 1'b1;
          wr_ok    = !excl_q || bus.tbl_match_i;
          set_hold = wr_ok;
          state_d  = ST_IDLE;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // A new lock in the same cycle as the old write's completion takes priority.
  always_comb begin
    hold_d      = hold_q;
    hold_addr_d = hold_addr_q;
    if (bus.wr_done_i) hold_d = 1'b0;
    if (set_hold) begin
      hold_d      = 1'b1;
      hold_addr_d = set_addr;
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q     <= ST_IDLE;
      addr_q      <= '0;
      id_q        <= '0;
      excl_q      <= 1'b0;
      hold_q      <= 1'b0;
      hold_addr_q <= '0;
    end else begin
      state_q     <= state_d;
      addr_q      <= addr_d;
      id_q        <= id_d;
      excl_q      <= excl_d;
      hold_q      <= hold_d;
      hold_addr_q <= hold_addr_d;
    end
  end

  assign bus.rd_gnt_o    = rd_gnt;
  assign bus.wr_gnt_o    = wr_gnt;
  assign bus.wr_ok_o     = wr_ok;
  assign bus.tbl_valid_o = tbl_valid;
  assign bus.tbl_op_o    = tbl_op;
  assign bus.tbl_addr_o  = tbl_valid ? addr_q : '0;
  assign bus.tbl_id_o    = tbl_valid ? id_q : '0;

  localparam bit GRAN_POW2 = (RESV_GRAN_BYTES != 32'd0) &&
                             ((RESV_GRAN_BYTES & (RESV_GRAN_BYTES - 32'd1)) == 32'd0);

  a_gran_pow2: assert property (@(posedge clk_i) GRAN_POW2);
  a_one_gnt:   assert property (@(posedge clk_i) disable iff (rst_i) !(rd_gnt && wr_gnt));
  a_op_none:   assert property (@(posedge clk_i) disable iff (rst_i) !tbl_valid |-> (tbl_op == OP_NONE));
  a_done_held: assert property (@(posedge clk_i) disable iff (rst_i) bus.wr_done_i |-> hold_q);

endmodule

// File: tb/tb_axi_riscv_resv_arbiter.sv
// Directed cycle-by-cycle vectors plus stall/reset sequences for axi_riscv_resv_arbiter.
module tb_axi_riscv_resv_arbiter;
  import axi_riscv_resv_pkg::*;

  // expected/actual packed as {rd_gnt, wr_gnt, wr_ok, tbl_valid, tbl_op[1:0], tbl_addr[31:0], tbl_id[3:0]}
  typedef logic [41:0] obs_t;
  localparam obs_t Z = '0;

  typedef struct {
    string       name;
    logic        rst;
    logic        rq;
    logic [31:0] ra;
    logic [3:0]  ri;
    logic        wq;
    logic [31:0] wa;
    logic [3:0]  wi;
    logic        wx;
    logic        dn;
    logic        rdy;
    logic        mt;
    obs_t        exp;
  } vec_t;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   n_vec = 0;
  int   n_bad = 0;

  always #5 clk = ~clk;

  axi_riscv_resv_arbiter_if #(.AXI_ADDR_WIDTH(32), .AXI_ID_WIDTH(4)) bus ();

  axi_riscv_resv_arbiter #(
    .ADDR_BEGIN      (64'h0),
    .ADDR_END        (64'hFFF),
    .AXI_ADDR_WIDTH  (32),
    .AXI_ID_WIDTH    (4),
    .RESV_GRAN_BYTES (8)
  ) dut (
    .clk_i (clk),
    .rst_i (rst),
    .bus   (bus)
  );

  function automatic obs_t E(input logic rg, input logic wg, input logic ok, input logic v,
                             input logic [1:0] op, input logic [31:0] a, input logic [3:0] id);
    return {rg, wg, ok, v, op, a, id};
  endfunction

  function automatic vec_t row(input string n, input logic r, input logic rq, input logic [31:0] ra,
                               input logic [3:0] ri, input logic wq, input logic [31:0] wa,
                               input logic [3:0] wi, input logic wx, input logic dn,
                               input logic rdy, input logic mt, input obs_t ex);
    vec_t v;
    v.name = n; v.rst = r; v.rq = rq; v.ra = ra; v.ri = ri; v.wq = wq; v.wa = wa; v.wi = wi;
    v.wx = wx; v.dn = dn; v.rdy = rdy; v.mt = mt; v.exp = ex;
    return v;
  endfunction

  task automatic drive(input vec_t v);
    rst             = v.rst;
    bus.rd_req_i    = v.rq;
    bus.rd_addr_i   = v.ra;
    bus.rd_id_i     = v.ri;
    bus.wr_req_i    = v.wq;
    bus.wr_addr_i   = v.wa;
    bus.wr_id_i     = v.wi;
    bus.wr_excl_i   = v.wx;
    bus.wr_done_i   = v.dn;
    bus.tbl_ready_i = v.rdy;
    bus.tbl_match_i = v.mt;
  endtask

  task automatic check(input string nm, input obs_t exp);
    obs_t a;
    a = {bus.rd_gnt_o, bus.wr_gnt_o, bus.wr_ok_o, bus.tbl_valid_o, bus.tbl_op_o,
         bus.tbl_addr_o, bus.tbl_id_o};
    n_vec++;
    if (a !== exp) begin
      n_bad++;
      $display("FAIL %s: got rg/wg/ok/v=%b op=%0d addr=%h id=%h, want rg/wg/ok/v=%b op=%0d addr=%h id=%h",
               nm, a[41:38], a[37:36], a[35:4], a[3:0], exp[41:38], exp[37:36], exp[35:4], exp[3:0]);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  initial begin
    vec_t vt[$];

    // name, rst, rd_req, rd_addr, rd_id, wr_req, wr_addr, wr_id, excl, done, ready, match, expected
    vt.push_back(row("reset",      1, 0, 32'h0,    0, 0, 32'h0,    0, 0, 0, 1, 0, Z));
    vt.push_back(row("lr_idle",    0, 1, 32'h100,  3, 0, 32'h0,    0, 0, 0, 1, 0, Z));
    vt.push_back(row("lr_set",     0, 1, 32'h100,  3, 0, 32'h0,    0, 0, 0, 1, 0, E(1,0,0,1,2'd1,32'h100,3)));
    vt.push_back(row("lr_drop",    0, 0, 32'h0,    0, 0, 32'h0,    0, 0, 0, 1, 0, Z));
    vt.push_back(row("sc_idle",    0, 0, 32'h0,    0, 1, 32'h100,  3, 1, 0, 1, 1, Z));
    vt.push_back(row("sc_chk",     0, 0, 32'h0,    0, 1, 32'h100,  3, 1, 0, 1, 1, E(0,1,1,1,2'd2,32'h100,3)));
    vt.push_back(row("lr_hold1",   0, 1, 32'h104,  5, 0, 32'h0,    0, 0, 0, 1, 0, Z));
    vt.push_back(row("lr_hold2",   0, 1, 32'h104,  5, 0, 32'h0,    0, 0, 0, 1, 0, Z));
    vt.push_back(row("lr_done",    0, 1, 32'h104,  5, 0, 32'h0,    0, 0, 1, 1, 0, Z));
    vt.push_back(row("lr_rel",     0, 1, 32'h104,  5, 0, 32'h0,    0, 0, 0, 1, 0, Z));
    vt.push_back(row("lr_set2",    0, 1, 32'h104,  5, 0, 32'h0,    0, 0, 0, 1, 0, E(1,0,0,1,2'd1,32'h100,5)));
    vt.push_back(row("idle1",      0, 0, 32'h0,    0, 0, 32'h0,    0, 0, 0, 1, 0, Z));
    vt.push_back(row("scf_idle",   0, 0, 32'h0,    0, 1, 32'h200,  2, 1, 0, 1, 0, Z));
    vt.push_back(row("scf_chk",    0, 0, 32'h0,    0, 1, 32'h200,  2, 1, 0, 1, 0, E(0,1,0,1,2'd2,32'h200,2)));
    vt.push_back(row("lr_nohold",  0, 1, 32'h200,  2, 0, 32'h0,    0, 0, 0, 1, 0, Z));
    vt.push_back(row("lr_nohold2", 0, 1, 32'h200,  2, 0, 32'h0,    0, 0, 0, 1, 0, E(1,0,0,1,2'd1,32'h200,2)));
    vt.push_back(row("reset2",     1, 0, 32'h0,    0, 0, 32'h0,    0, 0, 0, 1, 0, Z));
    vt.push_back(row("rr_idle0",   0, 1, 32'h300,  1, 1, 32'h400,  4, 1, 0, 1, 0, Z));
    vt.push_back(row("rr_rd0",     0, 1, 32'h300,  1, 1, 32'h400,  4, 1, 0, 1, 0, E(1,0,0,1,2'd1,32'h300,1)));
    vt.push_back(row("rr_idle1",   0, 1, 32'h300,  1, 1, 32'h400,  4, 1, 0, 1, 0, Z));
    vt.push_back(row("rr_wr1",     0, 1, 32'h300,  1, 1, 32'h400,  4, 1, 0, 1, 0, E(0,1,0,1,2'd2,32'h400,4)));
    vt.push_back(row("rr_idle2",   0, 1, 32'h300,  1, 1, 32'h400,  4, 1, 0, 1, 0, Z));
    vt.push_back(row("rr_rd2",     0, 1, 32'h300,  1, 1, 32'h400,  4, 1, 0, 1, 0, E(1,0,0,1,2'd1,32'h300,1)));
    vt.push_back(row("rr_idle3",   0, 1, 32'h300,  1, 1, 32'h400,  4, 1, 0, 1, 0, Z));
    vt.push_back(row("rr_wr3",     0, 1, 32'h300,  1, 1, 32'h400,  4, 1, 0, 1, 0, E(0,1,0,1,2'd2,32'h400,4)));
    vt.push_back(row("rr_drop",    0, 0, 32'h0,    0, 0, 32'h0,    0, 0, 0, 1, 0, Z));
    vt.push_back(row("oor_sc",     0, 0, 32'h0,    0, 1, 32'h2000, 1, 1, 0, 1, 0, E(0,1,0,0,2'd0,32'h0,0)));
    vt.push_back(row("oor_plain",  0, 0, 32'h0,    0, 1, 32'h2008, 1, 0, 0, 1, 0, E(0,1,1,0,2'd0,32'h0,0)));
    vt.push_back(row("oor_hold1",  0, 1, 32'h2008, 1, 1, 32'h500,  6, 0, 0, 1, 0, Z));
    vt.push_back(row("oor_hold2",  0, 1, 32'h2008, 1, 1, 32'h500,  6, 0, 1, 1, 0, Z));
    vt.push_back(row("oor_rd_tie", 0, 1, 32'h2008, 1, 1, 32'h500,  6, 0, 0, 1, 0, E(1,0,0,0,2'd0,32'h0,0)));
    vt.push_back(row("wr_idle",    0, 0, 32'h0,    0, 1, 32'h500,  6, 0, 0, 1, 0, Z));
    vt.push_back(row("wr_plain",   0, 0, 32'h0,    0, 1, 32'h500,  6, 0, 0, 1, 0, E(0,1,1,1,2'd2,32'h500,6)));
    vt.push_back(row("wr_done",    0, 0, 32'h0,    0, 0, 32'h0,    0, 0, 1, 1, 0, Z));
    vt.push_back(row("idle_end",   0, 0, 32'h0,    0, 0, 32'h0,    0, 0, 0, 1, 0, Z));

    drive(vt[0]);
    repeat (2) @(posedge clk);

    foreach (vt[i]) begin
      step();
      drive(vt[i]);
      @(negedge clk);
      check(vt[i].name, vt[i].exp);
    end

    // Table stalls for 5 cycles: request must stay valid with stable fields.
    step();
    bus.wr_req_i = 1; bus.wr_addr_i = 32'h60C; bus.wr_id_i = 7; bus.wr_excl_i = 1;
    bus.tbl_ready_i = 0; bus.tbl_match_i = 0;
    @(negedge clk); check("stall_idle", Z);
    for (int k = 1; k <= 5; k++) begin
      step();
      @(negedge clk); check($sformatf("stall_c%0d", k), E(0,0,0,1,2'd2,32'h608,7));
    end
    step();
    bus.tbl_ready_i = 1; bus.tbl_match_i = 1;
    @(negedge clk); check("stall_rel", E(0,1,1,1,2'd2,32'h608,7));
    step();
    bus.wr_req_i = 0; bus.wr_done_i = 1; bus.tbl_match_i = 0;
    @(negedge clk); check("stall_done", Z);

    // Stall again and reset in the third cycle; the pending grant is dropped.
    step();
    bus.wr_done_i = 0; bus.wr_req_i = 1; bus.wr_addr_i = 32'h610; bus.tbl_ready_i = 0;
    @(negedge clk); check("rst_idle", Z);
    for (int k = 1; k <= 2; k++) begin
      step();
      @(negedge clk); check($sformatf("rst_stall_c%0d", k), E(0,0,0,1,2'd2,32'h610,7));
    end
    step();
    rst = 1;
    @(negedge clk); check("rst_cycle", E(0,0,0,1,2'd2,32'h610,7));
    step();
    rst = 0; bus.tbl_ready_i = 1;
    @(negedge clk); check("post_rst_idle", Z);
    step();
    @(negedge clk); check("post_rst_op", E(0,1,0,1,2'd2,32'h610,7));
    step();
    bus.wr_req_i = 0;
    @(negedge clk); check("post_rst_end", Z);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
